// File: rtl/counter_cmd_gen.sv
// Command stage for the 5-bit up/down counter: synchronises, debounces and
// auto-repeats the push buttons and turns them into single-cycle load/up/down pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no direction active; waiting for an up/down press event
// ST_DELAY  | pulse emitted, counting down to the first auto-repeat
// ST_REPEAT | auto-repeating every REPEAT_RATE cycles while held
module counter_cmd_gen #(
    parameter int WIDTH       = 5,
    parameter int DB_CYCLES   = 4,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             btn_load_i,
    input  logic             btn_up_i,
    input  logic             btn_down_i,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             high_i,
    input  logic             low_i,
    output logic             load_o,
    output logic             up_o,
    output logic             down_o,
    output logic [WIDTH-1:0] in_o
);

    localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX);

    localparam int B_LD = 0;
    localparam int B_UP = 1;
    localparam int B_DN = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    state_t              state_q;
    dir_t                dir_q;
    logic [TW-1:0]       timer_q;

    logic [2:0]          btn;
    logic [2:0]          s1_q;
    logic [2:0]          s2_q;
    logic [2:0]          db_q;
    logic [2:0]          db_d;
    logic [2:0]          db_prev_q;
    logic [2:0][CW-1:0]  cnt_q;
    logic [2:0][CW-1:0]  cnt_d;
    logic [2:0]          press;
    logic                held_dir;

    assign btn      = {btn_down_i, btn_up_i, btn_load_i};
    assign press    = db_q & ~db_prev_q;
    assign held_dir = (dir_q == DIR_DN) ? db_q[B_DN] : db_q[B_UP];

    // The counter runs only while the synced level disagrees with the debounced one.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            timer_q   <= '0;
            load_o    <= 1'b0;
            up_o      <= 1'b0;
            down_o    <= 1'b0;
            in_o      <= '0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            load_o    <= 1'b0;
            up_o      <= 1'b0;
            down_o    <= 1'b0;

            if (press[B_LD]) begin
                load_o  <= 1'b1;
                in_o    <= sw_i;
                state_q <= ST_IDLE;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press[B_DN]) begin
                            dir_q   <= DIR_DN;
                            down_o  <= ~low_i;
                            state_q <= ST_DELAY;
                            timer_q <= TW'(REPEAT_DLY - 1);
                        end else if (press[B_UP]) begin
                            dir_q   <= DIR_UP;
                            up_o    <= ~high_i;
                            state_q <= ST_DELAY;
                            timer_q <= TW'(REPEAT_DLY - 1);
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!held_dir) begin
                            state_q <= ST_IDLE;
                        end else if (timer_q == '0) begin
                            // Flags gate the pulse only; the repeat cadence is unaffected.
                            up_o    <= (dir_q == DIR_UP) & ~high_i;
                            down_o  <= (dir_q == DIR_DN) & ~low_i;
                            state_q <= ST_REPEAT;
                            timer_q <= TW'(REPEAT_RATE - 1);
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
